// File: rtl/sweep_ctrl.sv
// sweep_ctrl: sequences an 8-bit up/down counter through triangle sweeps between lo and hi
// Optional feature macro: SWEEP_DWELL_EN (hold DWELL extra cycles at each non-final turnaround)
// Ports:
//   clk, clr            clock (rising edge) and asynchronous active-high reset
//   start, stop         single-cycle sweep request / abort request
//   lo, hi, cycles      bounds and sweep count (0 = continuous), latched on accepted start
//   count               counter output fed back to time turnarounds
//   ld, mode, din       counter load enable, direction (1 = up), load data
//   busy, done, err     not idle, final-sweep-complete pulse, rejected-start pulse
//   sweeps              completed sweeps modulo 16
module sweep_ctrl #(
    parameter int WIDTH = 8,
    parameter int DWELL = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic [3:0]       cycles,
    input  logic [WIDTH-1:0] count,
    output logic             ld,
    output logic             mode,
    output logic [WIDTH-1:0] din,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [3:0]       sweeps
);
`ifdef SWEEP_DWELL_EN
    typedef enum logic [2:0] {IDLE, LOAD, UP, DOWN, HOLD_HI, HOLD_LO} state_t;
    localparam int TW = (DWELL > 1) ? $clog2(DWELL) : 1;
    logic [TW-1:0] tmr, tmr_n;
`else
    typedef enum logic [2:0] {IDLE, LOAD, UP, DOWN} state_t;
    logic unused_dwell;
    assign unused_dwell = (DWELL != 0);
`endif
    state_t state, state_n;
    logic ld_n, mode_n, done_n, err_n;
    logic [WIDTH-1:0] din_n, lo_q, lo_n, hi_q, hi_n;
    logic [3:0] cyc_q, cyc_n, sweeps_n, sw_inc;
    assign sw_inc = sweeps + 4'd1;
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state  <= IDLE;
            ld     <= 1'b1;
            mode   <= 1'b0;
            din    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            sweeps <= '0;
            lo_q   <= '0;
            hi_q   <= '0;
            cyc_q  <= '0;
`ifdef SWEEP_DWELL_EN
            tmr    <= '0;
`endif
        end else begin
            state  <= state_n;
            ld     <= ld_n;
            mode   <= mode_n;
            din    <= din_n;
            busy   <= (state_n != IDLE);
            done   <= done_n;
            err    <= err_n;
            sweeps <= sweeps_n;
            lo_q   <= lo_n;
            hi_q   <= hi_n;
            cyc_q  <= cyc_n;
`ifdef SWEEP_DWELL_EN
            tmr    <= tmr_n;
`endif
        end
    end
    always_comb begin
        state_n  = state;
        ld_n     = ld;
        mode_n   = mode;
        din_n    = din;
        done_n   = 1'b0;
        err_n    = 1'b0;
        sweeps_n = sweeps;
        lo_n     = lo_q;
        hi_n     = hi_q;
        cyc_n    = cyc_q;
`ifdef SWEEP_DWELL_EN
        tmr_n    = tmr;
`endif
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    if (hi > lo) begin
                        lo_n     = lo;
                        hi_n     = hi;
                        cyc_n    = cycles;
                        sweeps_n = '0;
                        din_n    = lo;
                        state_n  = LOAD;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (stop) begin
                    din_n   = lo_q;
                    state_n = IDLE;
                end else begin
                    ld_n    = 1'b0;
                    mode_n  = 1'b1;
                    state_n = UP;
                end
            end
            UP: begin
                // The counter steps on this edge too, so parking at count+1 avoids a step back.
                if (stop) begin
                    ld_n    = 1'b1;
                    din_n   = count + WIDTH'(1);
                    state_n = IDLE;
                end else if (count == hi_q - WIDTH'(1)) begin
`ifdef SWEEP_DWELL_EN
                    if (DWELL > 0) begin
                        ld_n    = 1'b1;
                        din_n   = hi_q;
                        tmr_n   = '0;
                        state_n = HOLD_HI;
                    end else begin
                        mode_n  = 1'b0;
                        state_n = DOWN;
                    end
`else
                    mode_n  = 1'b0;
                    state_n = DOWN;
`endif
                end
            end
            DOWN: begin
                if (stop) begin
                    ld_n    = 1'b1;
                    din_n   = count - WIDTH'(1);
                    state_n = IDLE;
                end else if (count == lo_q + WIDTH'(1)) begin
                    sweeps_n = sw_inc;
                    if (cyc_q != 4'd0 && sw_inc == cyc_q) begin
                        ld_n    = 1'b1;
                        din_n   = lo_q;
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
`ifdef SWEEP_DWELL_EN
                        if (DWELL > 0) begin
                            ld_n    = 1'b1;
                            din_n   = lo_q;
                            tmr_n   = '0;
                            state_n = HOLD_LO;
                        end else begin
                            mode_n  = 1'b1;
                            state_n = UP;
                        end
`else
                        mode_n  = 1'b1;
                        state_n = UP;
`endif
                    end
                end
            end
`ifdef SWEEP_DWELL_EN
            // ld is still high on the exit edge, so the held value lasts DWELL+1 cycles.
            HOLD_HI: begin
                if (stop) begin
                    state_n = IDLE;
                end else if (tmr == TW'(DWELL - 1)) begin
                    ld_n    = 1'b0;
                    mode_n  = 1'b0;
                    state_n = DOWN;
                end else begin
                    tmr_n = tmr + TW'(1);
                end
            end
            HOLD_LO: begin
                if (stop) begin
                    state_n = IDLE;
                end else if (tmr == TW'(DWELL - 1)) begin
                    ld_n    = 1'b0;
                    mode_n  = 1'b1;
                    state_n = UP;
                end else begin
                    tmr_n = tmr + TW'(1);
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end
endmodule
